// File: rtl/board_sram_arbiter.sv
// ---------------------------------------------------------------------------
// board_sram_arbiter
//
// Shares the single-port 4-bit Trax board SRAM among three clients:
//   client 0 = force-move engine, client 1 = move placer, client 2 = display
//   scanner.
// A client asks for ownership with a level request. Ownership is granted
// round robin and held until the owner drops its request. Every release is
// followed by one IDLE cycle, which is the bus turnaround. While a client owns
// the bus, its address, write data and write enable drive the SRAM. SRAM read
// data and ready are returned to it. A sticky hold watchdog flags an owner
// that keeps the bus while another client is waiting.
//
// Parameters
//   depth      : MSB index of the SRAM address ({y, x}, depth+1 bits)
//   hold_w     : width of the hold counter
//   hold_limit : owner-held cycles, with another client waiting, that trip
//                the watchdog
//
// Ports
//   clk, reset            : clock; synchronous active-high reset
//   req[2:0]              : per-client ownership request (level)
//   addr0..2, wdata0..2   : per-client SRAM address and write data
//   we[2:0]               : per-client write enable (only the owner's is used)
//   gnt[2:0]              : registered one-hot grant (or zero)
//   rdata[3:0]            : SRAM read data, broadcast; valid only for the owner
//   ready[2:0]            : sram_ready qualified by gnt
//   sram_addr, sram_data_out, sram_write_en : SRAM command outputs
//   sram_data_in, sram_ready                : SRAM response inputs
//   busy                  : high while a client owns the bus (registered)
//   hold_timeout          : sticky watchdog flag, cleared only by reset
// ---------------------------------------------------------------------------
module board_sram_arbiter #(
  parameter int depth      = 21,
  parameter int hold_w     = 10,
  parameter int hold_limit = 1000
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [2:0]       req,
  input  logic [depth:0]   addr0,
  input  logic [depth:0]   addr1,
  input  logic [depth:0]   addr2,
  input  logic [3:0]       wdata0,
  input  logic [3:0]       wdata1,
  input  logic [3:0]       wdata2,
  input  logic [2:0]       we,
  output logic [2:0]       gnt,
  output logic [3:0]       rdata,
  output logic [2:0]       ready,
  output logic [depth:0]   sram_addr,
  output logic [3:0]       sram_data_out,
  output logic             sram_write_en,
  input  logic [3:0]       sram_data_in,
  input  logic             sram_ready,
  output logic             busy,
  output logic             hold_timeout
);

  typedef enum logic {
    IDLE = 1'b0,
    OWN  = 1'b1
  } state_t;

  // Value of hold_cnt on the edge that trips the watchdog.
  localparam logic [hold_w-1:0] hold_trip = hold_w'(hold_limit - 1);

  state_t            state_reg;
  logic [1:0]        owner_reg;
  logic [1:0]        last_reg;
  logic [hold_w-1:0] hold_cnt_reg;
  logic              hold_timeout_reg;
  logic              busy_reg;
  logic [2:0]        gnt_reg;

  // -------------------------------------------------------------------------
  // Round-robin winner selection
  // -------------------------------------------------------------------------
  // Candidates are visited in the order last+1, last+2, last (mod 3). The
  // previous owner therefore comes last but can still win when it is the
  // only requester.
  function automatic logic [1:0] next_client(input logic [1:0] c);
    return (c >= 2'd2) ? 2'd0 : c + 2'd1;
  endfunction

  // req is padded to four bits so that a 2-bit index is always in range.
  logic [3:0] req_ext;
  logic [1:0] cand1;
  logic [1:0] cand2;
  logic [1:0] winner;
  logic [2:0] winner_onehot;

  assign req_ext = {1'b0, req};

  always_comb begin
    cand1 = next_client(last_reg);
    cand2 = next_client(cand1);
    if (req_ext[cand1]) begin
      winner = cand1;
    end else if (req_ext[cand2]) begin
      winner = cand2;
    end else begin
      winner = last_reg;
    end
  end

  generate
    for (genvar gi = 0; gi < 3; gi++) begin : g_client
      assign winner_onehot[gi] = (winner == 2'(gi));
      // Ready reaches a client only while that client holds the grant.
      assign ready[gi]         = sram_ready & gnt_reg[gi];
    end
  endgenerate

  // gnt_reg is one-hot on the owner while in OWN and zero in IDLE, so it can
  // split req into the owner's request and the requests of waiting clients.
  logic owner_req;
  logic others_waiting;

  assign owner_req      = |(req & gnt_reg);
  assign others_waiting = |(req & ~gnt_reg);

  // -------------------------------------------------------------------------
  // Ownership FSM, hold counter and watchdog
  // -------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (reset) begin
      state_reg        <= IDLE;
      owner_reg        <= 2'd0;
      last_reg         <= 2'd2;  // client 0 is first in line after reset
      hold_cnt_reg     <= '0;
      hold_timeout_reg <= 1'b0;
      busy_reg         <= 1'b0;
      gnt_reg          <= 3'b000;
    end else begin
      case (state_reg)
        IDLE: begin
          if (|req) begin
            state_reg    <= OWN;
            owner_reg    <= winner;
            last_reg     <= winner;
            hold_cnt_reg <= '0;
            gnt_reg      <= winner_onehot;
            busy_reg     <= 1'b1;
          end
        end

        OWN: begin
          // The watchdog is only a flag. The owner keeps the grant.
          if (others_waiting && (hold_cnt_reg == hold_trip)) begin
            hold_timeout_reg <= 1'b1;
          end
          // Count only cycles in which another client is waiting. Saturate
          // so that a very long hold never wraps back below the trip point.
          if (others_waiting && (hold_cnt_reg != '1)) begin
            hold_cnt_reg <= hold_cnt_reg + 1'b1;
          end
          // Release always passes through IDLE, even if other clients are
          // already waiting.
          if (!owner_req) begin
            state_reg <= IDLE;
            gnt_reg   <= 3'b000;
            busy_reg  <= 1'b0;
          end
        end

        default: begin
          state_reg <= IDLE;
          gnt_reg   <= 3'b000;
          busy_reg  <= 1'b0;
        end
      endcase
    end
  end

  // -------------------------------------------------------------------------
  // SRAM command mux
  // -------------------------------------------------------------------------
  // The mux is combinational and adds no latency. Non-owner write enables
  // never reach the SRAM, and all outputs are held at zero while IDLE.
  always_comb begin
    sram_addr     = '0;
    sram_data_out = 4'h0;
    sram_write_en = 1'b0;
    if (state_reg == OWN) begin
      case (owner_reg)
        2'd0: begin
          sram_addr     = addr0;
          sram_data_out = wdata0;
          sram_write_en = we[0];
        end
        2'd1: begin
          sram_addr     = addr1;
          sram_data_out = wdata1;
          sram_write_en = we[1];
        end
        2'd2: begin
          sram_addr     = addr2;
          sram_data_out = wdata2;
          sram_write_en = we[2];
        end
        default: begin
          sram_addr     = '0;
          sram_data_out = 4'h0;
          sram_write_en = 1'b0;
        end
      endcase
    end
  end

  assign gnt          = gnt_reg;
  assign busy         = busy_reg;
  assign hold_timeout = hold_timeout_reg;
  assign rdata        = sram_data_in;

endmodule

// File: tb/tb_board_sram_arbiter.sv
// ---------------------------------------------------------------------------
// tb_board_sram_arbiter
//
// Directed bench for board_sram_arbiter. The design is built with
// hold_limit=8 so the watchdog can be reached in a few cycles. Inputs are
// driven 1 ns after a rising edge, and outputs are sampled at that same
// point. Combinational paths are checked after a further 1 ns of settling.
// ---------------------------------------------------------------------------
module tb_board_sram_arbiter;

  localparam int depth      = 21;
  localparam int hold_w     = 10;
  localparam int hold_limit = 8;

  logic             clk;
  logic             reset;
  logic [2:0]       req;
  logic [depth:0]   addr0, addr1, addr2;
  logic [3:0]       wdata0, wdata1, wdata2;
  logic [2:0]       we;
  logic [2:0]       gnt;
  logic [3:0]       rdata;
  logic [2:0]       ready;
  logic [depth:0]   sram_addr;
  logic [3:0]       sram_data_out;
  logic             sram_write_en;
  logic [3:0]       sram_data_in;
  logic             sram_ready;
  logic             busy;
  logic             hold_timeout;

  int vectors;
  int miscompares;

  board_sram_arbiter #(
    .depth      (depth),
    .hold_w     (hold_w),
    .hold_limit (hold_limit)
  ) dut (
    .clk           (clk),
    .reset         (reset),
    .req           (req),
    .addr0         (addr0),
    .addr1         (addr1),
    .addr2         (addr2),
    .wdata0        (wdata0),
    .wdata1        (wdata1),
    .wdata2        (wdata2),
    .we            (we),
    .gnt           (gnt),
    .rdata         (rdata),
    .ready         (ready),
    .sram_addr     (sram_addr),
    .sram_data_out (sram_data_out),
    .sram_write_en (sram_write_en),
    .sram_data_in  (sram_data_in),
    .sram_ready    (sram_ready),
    .busy          (busy),
    .hold_timeout  (hold_timeout)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    reset      = 1'b1;
    req        = 3'b000;
    we         = 3'b000;
    sram_ready = 1'b0;
    tick();
    tick();
    reset = 1'b0;
  endtask

  // -------------------------------------------------------------------------
  task automatic test_reset();
    reset = 1'b1;
    req   = 3'b111;
    for (int i = 0; i < 3; i++) begin
      tick();
      vectors++;
      if (gnt !== 3'b000) begin
        miscompares++;
        $display("FAIL reset_gnt[%0d]: got %b expected 000", i, gnt);
      end
      vectors++;
      if (sram_write_en !== 1'b0) begin
        miscompares++;
        $display("FAIL reset_we[%0d]: got %b expected 0", i, sram_write_en);
      end
      vectors++;
      if (hold_timeout !== 1'b0) begin
        miscompares++;
        $display("FAIL reset_timeout[%0d]: got %b expected 0", i, hold_timeout);
      end
      vectors++;
      if (busy !== 1'b0) begin
        miscompares++;
        $display("FAIL reset_busy[%0d]: got %b expected 0", i, busy);
      end
    end
    reset = 1'b0;
    tick();
    vectors++;
    if (gnt !== 3'b001) begin
      miscompares++;
      $display("FAIL reset_first_gnt: got %b expected 001", gnt);
    end
    vectors++;
    if (busy !== 1'b1) begin
      miscompares++;
      $display("FAIL reset_first_busy: got %b expected 1", busy);
    end
    $display("test_reset done, gnt=%b", gnt);
  endtask

  // -------------------------------------------------------------------------
  task automatic test_round_robin();
    logic [2:0] exp_order [4];
    exp_order[0] = 3'b001;
    exp_order[1] = 3'b010;
    exp_order[2] = 3'b100;
    exp_order[3] = 3'b001;
    do_reset();
    req = 3'b111;
    tick();
    for (int k = 0; k < 4; k++) begin
      vectors++;
      if (gnt !== exp_order[k]) begin
        miscompares++;
        $display("FAIL rr_grant[%0d]: got %b expected %b", k, gnt, exp_order[k]);
      end
      // Hold the grant for three more cycles.
      for (int h = 0; h < 3; h++) begin
        tick();
        vectors++;
        if (gnt !== exp_order[k]) begin
          miscompares++;
          $display("FAIL rr_hold[%0d.%0d]: got %b expected %b", k, h, gnt, exp_order[k]);
        end
      end
      // Owner drops its request, then re-raises it during the IDLE cycle.
      req = 3'b111 & ~exp_order[k];
      tick();
      vectors++;
      if (gnt !== 3'b000) begin
        miscompares++;
        $display("FAIL rr_idle[%0d]: got %b expected 000", k, gnt);
      end
      req = 3'b111;
      if (k < 3) tick();
      $display("round robin step %0d owner %b", k, exp_order[k]);
    end
    req = 3'b000;
    tick();
  endtask

  // -------------------------------------------------------------------------
  task automatic test_routing();
    do_reset();
    req = 3'b010;
    tick();
    vectors++;
    if (gnt !== 3'b010) begin
      miscompares++;
      $display("FAIL route_gnt: got %b expected 010", gnt);
    end
    addr1  = 22'h00C05;
    wdata1 = 4'hA;
    addr2  = 22'h3FFFF;
    wdata2 = 4'h5;
    we     = 3'b110;
    req    = 3'b110;
    #1;
    vectors++;
    if (sram_addr !== 22'h00C05) begin
      miscompares++;
      $display("FAIL route_addr: got %h expected 00c05", sram_addr);
    end
    vectors++;
    if (sram_data_out !== 4'hA) begin
      miscompares++;
      $display("FAIL route_data: got %h expected a", sram_data_out);
    end
    vectors++;
    if (sram_write_en !== 1'b1) begin
      miscompares++;
      $display("FAIL route_we: got %b expected 1", sram_write_en);
    end
    // Only the non-owner asserts a write now.
    we = 3'b100;
    tick();
    vectors++;
    if (sram_write_en !== 1'b0) begin
      miscompares++;
      $display("FAIL route_suppress_we: got %b expected 0", sram_write_en);
    end
    vectors++;
    if (sram_data_out !== 4'hA) begin
      miscompares++;
      $display("FAIL route_suppress_data: got %h expected a", sram_data_out);
    end
    // Placer releases. Client 2's write must not leak out during IDLE.
    req = 3'b100;
    tick();
    vectors++;
    if (gnt !== 3'b000) begin
      miscompares++;
      $display("FAIL route_release_gnt: got %b expected 000", gnt);
    end
    vectors++;
    if (sram_write_en !== 1'b0 || sram_addr !== 22'h0) begin
      miscompares++;
      $display("FAIL route_idle_outputs: got we=%b addr=%h expected we=0 addr=0",
               sram_write_en, sram_addr);
    end
    tick();
    vectors++;
    if (gnt !== 3'b100) begin
      miscompares++;
      $display("FAIL route_next_gnt: got %b expected 100", gnt);
    end
    $display("test_routing done, sram_addr=%h", sram_addr);
    we  = 3'b000;
    req = 3'b000;
    tick();
  endtask

  // -------------------------------------------------------------------------
  task automatic test_ready();
    do_reset();
    req = 3'b001;
    tick();
    sram_ready   = 1'b1;
    sram_data_in = 4'h6;
    #1;
    vectors++;
    if (ready !== 3'b001) begin
      miscompares++;
      $display("FAIL ready_owner: got %b expected 001", ready);
    end
    vectors++;
    if (rdata !== 4'h6) begin
      miscompares++;
      $display("FAIL ready_rdata: got %h expected 6", rdata);
    end
    sram_ready = 1'b0;
    #1;
    vectors++;
    if (ready !== 3'b000) begin
      miscompares++;
      $display("FAIL ready_low: got %b expected 000", ready);
    end
    req = 3'b000;
    tick();
    sram_ready = 1'b1;
    #1;
    vectors++;
    if (ready !== 3'b000) begin
      miscompares++;
      $display("FAIL ready_no_owner: got %b expected 000", ready);
    end
    sram_ready = 1'b0;
    $display("test_ready done");
  endtask

  // -------------------------------------------------------------------------
  task automatic test_watchdog();
    do_reset();
    req = 3'b001;
    tick();
    req = 3'b101;
    for (int c = 1; c <= 10; c++) begin
      tick();
      vectors++;
      if (hold_timeout !== (c >= hold_limit)) begin
        miscompares++;
        $display("FAIL wd_flag[%0d]: got %b expected %b", c, hold_timeout, (c >= hold_limit));
      end
      vectors++;
      if (gnt !== 3'b001) begin
        miscompares++;
        $display("FAIL wd_no_preempt[%0d]: got %b expected 001", c, gnt);
      end
    end
    req = 3'b100;
    tick();
    vectors++;
    if (gnt !== 3'b000 || hold_timeout !== 1'b1) begin
      miscompares++;
      $display("FAIL wd_release: got gnt=%b to=%b expected gnt=000 to=1", gnt, hold_timeout);
    end
    tick();
    vectors++;
    if (gnt !== 3'b100 || hold_timeout !== 1'b1) begin
      miscompares++;
      $display("FAIL wd_next: got gnt=%b to=%b expected gnt=100 to=1", gnt, hold_timeout);
    end
    $display("test_watchdog done, hold_timeout=%b", hold_timeout);
    req = 3'b000;
    tick();
  endtask

  // -------------------------------------------------------------------------
  task automatic test_reset_mid();
    do_reset();
    req   = 3'b010;
    tick();
    addr1 = 22'h12345;
    we    = 3'b010;
    #1;
    vectors++;
    if (gnt !== 3'b010 || sram_write_en !== 1'b1) begin
      miscompares++;
      $display("FAIL rmid_own: got gnt=%b we=%b expected gnt=010 we=1", gnt, sram_write_en);
    end
    reset = 1'b1;
    req   = 3'b011;
    tick();
    vectors++;
    if (gnt !== 3'b000 || sram_write_en !== 1'b0) begin
      miscompares++;
      $display("FAIL rmid_drop: got gnt=%b we=%b expected gnt=000 we=0", gnt, sram_write_en);
    end
    reset = 1'b0;
    tick();
    vectors++;
    if (gnt !== 3'b001) begin
      miscompares++;
      $display("FAIL rmid_first: got %b expected 001", gnt);
    end
    $display("test_reset_mid done, gnt=%b", gnt);
    we  = 3'b000;
    req = 3'b000;
    tick();
  endtask

  // -------------------------------------------------------------------------
  task automatic test_back_to_back();
    // A lone requester that was also the last owner re-acquires after one
    // IDLE cycle.
    do_reset();
    req = 3'b100;
    tick();
    vectors++;
    if (gnt !== 3'b100) begin
      miscompares++;
      $display("FAIL b2b_first: got %b expected 100", gnt);
    end
    req = 3'b000;
    tick();
    vectors++;
    if (gnt !== 3'b000 || busy !== 1'b0) begin
      miscompares++;
      $display("FAIL b2b_idle: got gnt=%b busy=%b expected gnt=000 busy=0", gnt, busy);
    end
    req = 3'b100;
    tick();
    vectors++;
    if (gnt !== 3'b100) begin
      miscompares++;
      $display("FAIL b2b_again: got %b expected 100", gnt);
    end
    $display("test_back_to_back done, gnt=%b", gnt);
    req = 3'b000;
    tick();
  endtask

  initial begin
    vectors      = 0;
    miscompares  = 0;
    reset        = 1'b1;
    req          = 3'b000;
    addr0        = 22'h00001;
    addr1        = 22'h00002;
    addr2        = 22'h00003;
    wdata0       = 4'h1;
    wdata1       = 4'h2;
    wdata2       = 4'h3;
    we           = 3'b000;
    sram_data_in = 4'h0;
    sram_ready   = 1'b0;

    test_reset();
    test_round_robin();
    test_routing();
    test_ready();
    test_watchdog();
    test_reset_mid();
    test_back_to_back();

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
